instruction_fetch_queue: RTL
============================

Name: instruction_fetch_queue

Overview:
- Parametrised next-generation fetch stage for the single-cycle MIPS core.
- Holds the fetch PC, reads an internal writable instruction memory, and computes branch/jump redirect targets.
- Buffers fetched {pc, instruction} pairs in a FIFO prefetch queue with a valid/ready handshake to decode.
- Decode can stall without losing fetched words; a redirect flushes the queue and restarts fetch at the target.

Parameters:
- ADDR_WIDTH, 32, width of PC and all byte addresses (min 30).
- MEM_DEPTH, 256, instruction memory size in 32-bit words; power of two.
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 0, byte address fetched first after reset; word aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  suppresses new fetches (no push, PC held); queue still drains.
- redirectBranch  in  1  taken branch; target = redirectPc + 4 + (redirectImm << 2).
- redirectJump  in  1  jump; target = {(redirectPc+4)[ADDR_WIDTH-1:28], redirectIndex, 2'b00}.
- redirectPc  in  ADDR_WIDTH  PC of the control instruction.
- redirectImm  in  ADDR_WIDTH  sign-extended branch word offset.
- redirectIndex  in  26  jump word index.
- memWriteEnable  in  1  instruction memory load strobe.
- memWriteAddr  in  log2(MEM_DEPTH)  word index to write.
- memWriteData  in  32  word to write.
- instrReady  in  1  decode accepts head entry.
- instrValid  out  1  head entry present (count != 0).
- instruction  out  32  head entry instruction.
- instrPc  out  ADDR_WIDTH  head entry PC.
- pcDisplay  out  ADDR_WIDTH  current fetch PC, for the board display.

Behaviour:
- Reset (synchronous, active-high):
  - fetch PC <= RESET_PC.
  - Queue count, read pointer and write pointer <= 0.
  - instrValid = 0; instruction = 0 and instrPc = 0 while empty.
  - Memory contents are not cleared.
- Memory:
  - Combinational read at word index pc[log2(MEM_DEPTH)+1:2]; address wraps modulo MEM_DEPTH.
  - Synchronous write.
  - Same-cycle write and fetch to the same word: fetch gets the old data; the new data is visible the next cycle.
- Arithmetic:
  - All additions are modulo 2^ADDR_WIDTH.
  - pc[1:0] is always 0; target low bits are forced to 0.
- Cycle priority, highest first:
  1. reset.
  2. redirect (redirectJump | redirectBranch).
     - PC <= target; jump wins when both are asserted.
     - Queue flushed (count and both pointers to 0).
     - No push that cycle.
     - An instrValid&instrReady in the same cycle counts as consumed by decode; the entry is discarded by the flush.
  3. normal operation.
     - pop = instrValid & instrReady.
     - push = !freeze & (count < QUEUE_DEPTH | pop).
     - On push: write {pc, mem[pc]} at wrPtr and PC <= PC + 4.
     - count <= count + push - pop.
- Full queue: push and pop together are allowed; count stays at QUEUE_DEPTH.
- Empty queue: pop is impossible (instrValid = 0).
- Pointers wrap modulo QUEUE_DEPTH.
- Latency:
  - The first push occurs on the first edge with reset low; instrValid rises the following cycle.
  - Redirect at edge N: target pushed at edge N+1, instrValid at N+1. That is one bubble cycle.
- Queue outputs come from registered storage only; the memory output has no combinational path to instruction.
- freeze together with redirect: redirect still applies; fetch of the target waits until freeze drops.
- Reset asserted mid-stream: the queue is emptied and fetch restarts at RESET_PC regardless of other inputs.

Test Plan:
- Reset, preload mem[0..7] = 0x1000_0000+i, instrReady=1 -> instrValid high from cycle 1; instruction 0x1000_0000..07 in order; instrPc 0x0,0x4,...,0x1C; one per cycle.
- instrReady=0 for 10 cycles -> exactly 4 entries queued; pcDisplay stops at 0x10; releasing ready delivers PCs 0x0..0xC, then 0x10 with no loss or duplication.
- Full queue with ready=1 -> push and pop each cycle; count stays 4; throughput one per cycle.
- redirectBranch, redirectPc=0x20, redirectImm=-3 (0xFFFF_FFFD) -> target 0x18; queue flushed; instrValid low for one cycle; next instrPc = 0x18.
- redirectJump and redirectBranch together, redirectPc=0x1000_0004, redirectIndex=0x40 -> target 0x1000_0100 (jump wins).
- PC reaches 0x3FC with MEM_DEPTH=256 -> next fetch 0x400 reads mem[0] (wrap); reset asserted with a full queue -> instrValid=0 next cycle and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch stage for the MIPS core: fetch PC, writable instruction memory, redirect
// target generation and a prefetch FIFO handing {pc, instruction} to decode.
module instruction_fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         freeze,
  input  logic                         redirectBranch,
  input  logic                         redirectJump,
  input  logic [ADDR_WIDTH-1:0]        redirectPc,
  input  logic [ADDR_WIDTH-1:0]        redirectImm,
  input  logic [25:0]                  redirectIndex,
  input  logic                         memWriteEnable,
  input  logic [$clog2(MEM_DEPTH)-1:0] memWriteAddr,
  input  logic [31:0]                  memWriteData,
  input  logic                         instrReady,
  output logic                         instrValid,
  output logic [31:0]                  instruction,
  output logic [ADDR_WIDTH-1:0]        instrPc,
  output logic [ADDR_WIDTH-1:0]        pcDisplay
);
  localparam int MW = $clog2(MEM_DEPTH);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } fq_entry_t;

  logic [31:0]           mem [MEM_DEPTH];
  fq_entry_t             q   [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc, pc4_r, br_tgt, jmp_tgt, tgt;
  logic [QW-1:0]         rd_ptr, wr_ptr;
  logic [QW:0]           cnt;
  logic [31:0]           fetch_word;
  logic                  redirect, push, pop;

  // Address wraps modulo MEM_DEPTH by taking only the word-index bits.
  assign fetch_word = mem[pc[MW+1:2]];

  assign pc4_r    = redirectPc + ADDR_WIDTH'(4);
  assign br_tgt   = (pc4_r + (redirectImm << 2)) & ~ADDR_WIDTH'(3);
  assign jmp_tgt  = {pc4_r[ADDR_WIDTH-1:28], redirectIndex, 2'b00};
  assign tgt      = redirectJump ? jmp_tgt : br_tgt;
  assign redirect = redirectJump | redirectBranch;

  assign instrValid  = (cnt != '0);
  assign pop         = instrValid & instrReady;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push        = !freeze & ((cnt < QFULL) | pop);
  assign instruction = instrValid ? q[rd_ptr].instr : '0;
  assign instrPc     = instrValid ? q[rd_ptr].pc    : '0;
  assign pcDisplay   = pc;

  // Contents survive reset; a same-edge fetch sees the pre-write word.
  always_ff @(posedge clk)
    if (memWriteEnable) mem[memWriteAddr] <= memWriteData;

  always_ff @(posedge clk)
    if (!reset && !redirect && push) q[wr_ptr] <= '{pc: pc, instr: fetch_word};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      // Flush; a head accepted this cycle is simply dropped with the rest.
      pc     <= tgt;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + QW'(1);
        pc     <= pc + ADDR_WIDTH'(4);
      end
      if (pop) rd_ptr <= rd_ptr + QW'(1);
      cnt <= cnt + (QW+1)'(push) - (QW+1)'(pop);
    end
  end
endmodule
